maze_move_sequencer: RTL and testbench

Cell-granular game controller for the 15x15 maze display path. It owns the player cell, the coin sequence, the score and the game phase. It issues one move per move tick and checks each move against the wall nibbles fetched from the maze row store. The pixel renderer reads its outputs; the renderer does not move the player itself.

---
 rtl/maze_move_sequencer_pkg.sv | 53 +++++
 rtl/maze_move_sequencer_if.sv | 14 +
 rtl/maze_move_sequencer_tick_gen.sv | 28 ++
 rtl/maze_move_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_maze_move_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_move_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze game controller and the pixel renderer:
// maze geometry, wall nibble bit positions, phase and direction codes, the
// controller state encoding and the renderer colour constants.
// ---------------------------------------------------------------------------
package maze_pkg;

  localparam int         MAZE_DIM = 15;
  localparam logic [3:0] MAZE_MAX = 4'(MAZE_DIM - 1);

  // Bit positions inside a 4-bit cell nibble
  localparam int WALL_UP    = 3;
  localparam int WALL_RIGHT = 2;
  localparam int WALL_DOWN  = 1;
  localparam int WALL_LEFT  = 0;

  // Renderer background select
  typedef enum logic [1:0] {
    PHASE_INI  = 2'b00,
    PHASE_PLAY = 2'b01,
    PHASE_DONE = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_INI   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 12-bit RGB colours used by the renderer
  localparam logic [11:0] COLOUR_WALL   = 12'hFFF;
  localparam logic [11:0] COLOUR_PLAYER = 12'h0F0;
  localparam logic [11:0] COLOUR_COIN   = 12'hFF0;

  // Column 0 sits in the most significant nibble of a 60-bit row word.
  function automatic logic [3:0] cell_nibble(input logic [59:0] row,
                                             input logic [3:0]  col);
    logic [5:0] base;
    base = 6'd59 - {col, 2'b00};
    return row[base -: 4];
  endfunction

endpackage

// File: rtl/maze_move_sequencer_if.sv
// ---------------------------------------------------------------------------
// maze_move_sequencer_if
// Read port of the maze row store.
//   maze_row_addr : row index driven by the controller (master)
//   maze_row_data : 60-bit row word, 15 nibbles, valid one cycle after the
//                   address is driven (slave)
// ---------------------------------------------------------------------------
interface maze_move_sequencer_if;
  logic [3:0]  maze_row_addr;
  logic [59:0] maze_row_data;

  modport master (output maze_row_addr, input  maze_row_data);
  modport slave  (input  maze_row_addr, output maze_row_data);
endinterface

// File: rtl/maze_move_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// move_tick_gen
// Free-running move-opportunity divider. Counts 0..TICK_DIV-1 and raises
// tick for the single cycle in which the count sits at its terminal value.
//   move_clk : clock
//   Reset_n  : asynchronous active-low reset (count returns to 0)
//   tick     : one-cycle strobe
// ---------------------------------------------------------------------------
module move_tick_gen #(
  parameter logic [23:0] TICK_DIV = 24'd2500000
) (
  input  logic move_clk,
  input  logic Reset_n,
  output logic tick
);

  logic [23:0] count_reg;
  logic [23:0] count_next;

  assign tick       = (count_reg == TICK_DIV - 24'd1);
  assign count_next = tick ? 24'd0 : count_reg + 24'd1;

  always_ff @(posedge move_clk or negedge Reset_n) begin
    if (!Reset_n) count_reg <= 24'd0;
    else          count_reg <= count_next;
  end

endmodule

// File: rtl/maze_move_sequencer.sv
// ---------------------------------------------------------------------------
// maze_move_sequencer
// Cell-granular controller for the 15x15 maze. Owns the player cell, the
// coin sequence, the score and the game phase; performs at most one move
// per tick, validated against the wall nibble of the player's current cell.
// Ports:
//   move_clk, Reset_n        : clock, asynchronous active-low reset
//   Up/Down/Left/Right       : level-held direction buttons
//   row_bus (master)         : maze row store read port
//   player_row/player_col    : current player cell
//   coin_row/coin_col        : active coin cell, coin_valid while one exists
//   score                    : coins collected (saturating)
//   finish_open              : every coin collected
//   game_done                : player reached the open finish
//   phase                    : 00 INI, 01 PLAY, 10 DONE
// ---------------------------------------------------------------------------
module maze_move_sequencer
  import maze_pkg::*;
#(
  parameter logic [23:0] TICK_DIV   = 24'd2500000,
  parameter int          NUM_COINS  = 4,
  parameter logic [63:0] COIN_CELLS = 64'h0000_0000_1E05_E2D3,
  parameter logic [3:0]  START_ROW  = 4'd14,
  parameter logic [3:0]  START_COL  = 4'd0,
  parameter logic [3:0]  FINISH_ROW = 4'd0,
  parameter logic [3:0]  FINISH_COL = 4'd14
) (
  input  logic                         move_clk,
  input  logic                         Reset_n,
  input  logic                         Up,
  input  logic                         Down,
  input  logic                         Left,
  input  logic                         Right,
  maze_move_sequencer_if.master        row_bus,
  output logic [3:0]                   player_row,
  output logic [3:0]                   player_col,
  output logic [3:0]                   coin_row,
  output logic [3:0]                   coin_col,
  output logic                         coin_valid,
  output logic [3:0]                   score,
  output logic                         finish_open,
  output logic                         game_done,
  output logic [1:0]                   phase
);

  localparam logic [3:0] NUM_IDX = 4'(NUM_COINS);

  logic tick;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .move_clk (move_clk),
    .Reset_n  (Reset_n),
    .tick     (tick)
  );

  // Coin cells unpacked into a lookup table, entry k = {row, col} of coin k
  logic [7:0] coin_table [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_coin_table
      assign coin_table[gi] = COIN_CELLS[8*gi +: 8];
    end
  endgenerate

  state_t     state_reg,       state_next;
  dir_t       dir_reg,         dir_next;
  logic [3:0] row_reg,         row_next;
  logic [3:0] col_reg,         col_next;
  logic [3:0] addr_reg,        addr_next;
  logic [3:0] coin_idx_reg,    coin_idx_next;
  logic [7:0] coin_cell_reg,   coin_cell_next;
  logic       coin_valid_reg,  coin_valid_next;
  logic [3:0] score_reg,       score_next;
  logic       finish_open_reg, finish_open_next;

  logic [3:0] nibble;
  logic [3:0] cand_row, cand_col;
  logic       blocked;

  // Candidate cell and legality of the latched move
  always_comb begin
    nibble   = cell_nibble(row_bus.maze_row_data, col_reg);
    cand_row = row_reg;
    cand_col = col_reg;
    blocked  = 1'b0;
    unique case (dir_reg)
      DIR_RIGHT: begin
        blocked  = nibble[WALL_RIGHT] || (col_reg >= MAZE_MAX);
        cand_col = col_reg + 4'd1;
      end
      DIR_LEFT: begin
        blocked  = nibble[WALL_LEFT] || (col_reg == 4'd0);
        cand_col = col_reg - 4'd1;
      end
      DIR_UP: begin
        blocked  = nibble[WALL_UP] || (row_reg == 4'd0);
        cand_row = row_reg - 4'd1;
      end
      DIR_DOWN: begin
        blocked  = nibble[WALL_DOWN] || (row_reg >= MAZE_MAX);
        cand_row = row_reg + 4'd1;
      end
      default: blocked = 1'b1;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_next       = state_reg;
    dir_next         = dir_reg;
    row_next         = row_reg;
    col_next         = col_reg;
    addr_next        = addr_reg;
    coin_idx_next    = coin_idx_reg;
    coin_cell_next   = coin_cell_reg;
    coin_valid_next  = coin_valid_reg;
    score_next       = score_reg;
    finish_open_next = finish_open_reg;

    unique case (state_reg)
      ST_INI: state_next = ST_WAIT;

      ST_WAIT: begin
        if (tick && (Right || Left || Up || Down)) begin
          if (Right)     dir_next = DIR_RIGHT;
          else if (Left) dir_next = DIR_LEFT;
          else if (Up)   dir_next = DIR_UP;
          else           dir_next = DIR_DOWN;
          // Registered so the row word is present during CHECK
          addr_next  = row_reg;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: state_next = ST_CHECK;

      ST_CHECK: begin
        state_next = ST_WAIT;
        if (!blocked) begin
          row_next = cand_row;
          col_next = cand_col;
          if (coin_valid_reg && ({cand_row, cand_col} == coin_cell_reg)) begin
            score_next    = (score_reg == 4'hF) ? score_reg : score_reg + 4'd1;
            coin_idx_next = coin_idx_reg + 4'd1;
            if (coin_idx_next == NUM_IDX) begin
              // Coin outputs keep showing the last coin
              coin_valid_next  = 1'b0;
              finish_open_next = 1'b1;
            end else begin
              coin_cell_next = coin_table[coin_idx_next[2:0]];
            end
          end
          // Uses the post-collect flag so a coin on the finish cell ends the game at once
          if (finish_open_next && (cand_row == FINISH_ROW) && (cand_col == FINISH_COL))
            state_next = ST_DONE;
        end
      end

      ST_DONE: state_next = ST_DONE;

      default: state_next = ST_INI;
    endcase
  end

  always_ff @(posedge move_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= ST_INI;
      dir_reg         <= DIR_RIGHT;
      row_reg         <= START_ROW;
      col_reg         <= START_COL;
      addr_reg        <= START_ROW;
      coin_idx_reg    <= 4'd0;
      coin_cell_reg   <= COIN_CELLS[7:0];
      coin_valid_reg  <= (NUM_COINS >= 1);
      score_reg       <= 4'd0;
      finish_open_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dir_reg         <= dir_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      addr_reg        <= addr_next;
      coin_idx_reg    <= coin_idx_next;
      coin_cell_reg   <= coin_cell_next;
      coin_valid_reg  <= coin_valid_next;
      score_reg       <= score_next;
      finish_open_reg <= finish_open_next;
    end
  end

  assign row_bus.maze_row_addr = addr_reg;
  assign player_row  = row_reg;
  assign player_col  = col_reg;
  assign coin_row    = coin_cell_reg[7:4];
  assign coin_col    = coin_cell_reg[3:0];
  assign coin_valid  = coin_valid_reg;
  assign score       = score_reg;
  assign finish_open = finish_open_reg;
  assign game_done   = (state_reg == ST_DONE);
  assign phase       = (state_reg == ST_INI)  ? PHASE_INI  :
                       (state_reg == ST_DONE) ? PHASE_DONE : PHASE_PLAY;

endmodule

// File: tb/tb_maze_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_maze_move_sequencer
// Directed walk through the maze followed by random moves over random walls,
// each move predicted by a cell-level game model.
// ---------------------------------------------------------------------------
module tb_maze_move_sequencer;

  localparam int          TD         = 4;
  localparam logic [23:0] TICK_DIV   = 24'd4;
  localparam int          NUM_COINS  = 4;
  // coin0 (13,3) coin1 (14,2) coin2 (0,5) coin3 (1,14)
  localparam logic [63:0] COIN_CELLS = 64'h0000_0000_1E05_E2D3;

  int coin_r [NUM_COINS] = '{13, 14, 0, 1};
  int coin_c [NUM_COINS] = '{3, 2, 5, 14};

  logic        move_clk = 1'b0;
  logic        Reset_n  = 1'b0;
  logic        Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0;
  logic [3:0]  player_row, player_col, coin_row, coin_col, score;
  logic        coin_valid, finish_open, game_done;
  logic [1:0]  phase;

  maze_move_sequencer_if bus ();

  maze_move_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .NUM_COINS  (NUM_COINS),
    .COIN_CELLS (COIN_CELLS),
    .START_ROW  (4'd14),
    .START_COL  (4'd0),
    .FINISH_ROW (4'd0),
    .FINISH_COL (4'd14)
  ) dut (
    .move_clk    (move_clk),
    .Reset_n     (Reset_n),
    .Up          (Up),
    .Down        (Down),
    .Left        (Left),
    .Right       (Right),
    .row_bus     (bus),
    .player_row  (player_row),
    .player_col  (player_col),
    .coin_row    (coin_row),
    .coin_col    (coin_col),
    .coin_valid  (coin_valid),
    .score       (score),
    .finish_open (finish_open),
    .game_done   (game_done),
    .phase       (phase)
  );

  always #5 move_clk = ~move_clk;

  // Maze row store: one-cycle registered read
  logic [59:0] rows [16];
  always @(posedge move_clk) bus.maze_row_data <= rows[bus.maze_row_addr];

  // Bench copy of the move-opportunity schedule
  int tb_cnt;
  always @(posedge move_clk or negedge Reset_n) begin
    if (!Reset_n)           tb_cnt <= 0;
    else if (tb_cnt == TD-1) tb_cnt <= 0;
    else                    tb_cnt <= tb_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Game model
  int m_row, m_col, m_idx, m_score, m_phase;
  bit m_done;

  task automatic model_reset();
    m_row = 14; m_col = 0; m_idx = 0; m_score = 0; m_done = 0; m_phase = 0;
  endtask

  task automatic model_step(input logic [3:0] btn);  // btn = {R,L,U,D}
    int dr, dc, wb, walls, nr, nc;
    dr = 0; dc = 0; wb = 0;
    if (m_done || btn == 4'b0) return;
    if (btn[3])      begin dc =  1; wb = 2; end
    else if (btn[2]) begin dc = -1; wb = 0; end
    else if (btn[1]) begin dr = -1; wb = 3; end
    else             begin dr =  1; wb = 1; end
    walls = int'((rows[m_row] >> (4 * (14 - m_col))) & 60'hF);
    nr = m_row + dr;
    nc = m_col + dc;
    if (((walls >> wb) & 1) == 1 || nr < 0 || nr > 14 || nc < 0 || nc > 14) return;
    m_row = nr;
    m_col = nc;
    if (m_idx < NUM_COINS && nr == coin_r[m_idx] && nc == coin_c[m_idx]) begin
      m_idx++;
      if (m_score < 15) m_score++;
    end
    if (m_idx == NUM_COINS && nr == 0 && nc == 14) begin
      m_done = 1;
      m_phase = 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    int ci;
    ci = (m_idx < NUM_COINS) ? m_idx : NUM_COINS - 1;
    chk({tag, "/player_row"},  32'(player_row),  m_row);
    chk({tag, "/player_col"},  32'(player_col),  m_col);
    chk({tag, "/score"},       32'(score),       m_score);
    chk({tag, "/coin_row"},    32'(coin_row),    coin_r[ci]);
    chk({tag, "/coin_col"},    32'(coin_col),    coin_c[ci]);
    chk({tag, "/coin_valid"},  32'(coin_valid),  32'(m_idx < NUM_COINS));
    chk({tag, "/finish_open"}, 32'(finish_open), 32'(m_idx >= NUM_COINS));
    chk({tag, "/game_done"},   32'(game_done),   32'(m_done));
    chk({tag, "/phase"},       32'(phase),       m_phase);
  endtask

  // Leaves the bench #1 into a cycle whose count is 0
  task automatic wait_cnt0();
    @(posedge move_clk); #1;
    for (int i = 0; i < TD && tb_cnt != 0; i++) begin
      @(posedge move_clk); #1;
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    {Right, Left, Up, Down} = 4'b0;
    model_reset();
    repeat (2) @(posedge move_clk);
    #1;
    check_all("reset");
    chk("reset/addr", 32'(bus.maze_row_addr), 14);
    @(negedge move_clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge move_clk);
    #1;
    m_phase = 1;
  endtask

  // One button press spanning exactly one tick; checks the T+2/T+3 timing
  task automatic do_move(input logic [3:0] btn, input string tag);
    int old_r, old_c;
    bit live;
    wait_cnt0();
    {Right, Left, Up, Down} = btn;
    repeat (TD) @(posedge move_clk);
    #1;
    {Right, Left, Up, Down} = 4'b0;
    live = (btn != 4'b0) && !m_done;
    old_r = m_row;
    old_c = m_col;
    if (live) chk({tag, "/fetch_addr"}, 32'(bus.maze_row_addr), m_row);
    @(posedge move_clk); #1;
    if (live) begin
      chk({tag, "/hold_row"}, 32'(player_row), old_r);
      chk({tag, "/hold_col"}, 32'(player_col), old_c);
    end
    @(posedge move_clk); #1;
    model_step(btn);
    check_all(tag);
  endtask

  localparam logic [3:0] B_R = 4'b1000, B_L = 4'b0100, B_U = 4'b0010, B_D = 4'b0001;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 16; r++) rows[r] = 60'h0;

    // Reset and idle ticks
    do_reset();
    repeat (3 * TD) @(posedge move_clk);
    #1;
    check_all("idle");
    chk("idle/addr", 32'(bus.maze_row_addr), 14);

    // Right wall blocks, then open cell with down/left walls lets Right through
    rows[14] = {4'h7, 56'h0};
    do_move(B_R, "right_wall");
    chk("right_wall/col", 32'(player_col), 0);
    rows[14] = {4'h3, 56'h0};
    do_move(B_R, "right_open");
    chk("right_open/col", 32'(player_col), 1);
    rows[14] = 60'h0;

    // Left edge bound
    do_move(B_L, "left_back");
    do_move(B_L, "left_bound");
    chk("left_bound/col", 32'(player_col), 0);

    // Right beats Up
    do_move(B_R | B_U, "prio");
    chk("prio/row", 32'(player_row), 14);
    chk("prio/col", 32'(player_col), 1);

    // Coin 1 cell while coin 0 active, then collect 0 and 1
    do_move(B_R, "coin1_early");
    chk("coin1_early/score", 32'(score), 0);
    do_move(B_R, "to_14_3");
    do_move(B_U, "coin0");
    chk("coin0/score", 32'(score), 1);
    do_move(B_D, "back_down");
    do_move(B_L, "coin1");
    chk("coin1/score", 32'(score), 2);

    // Up to the top row, across to coin 2
    for (int i = 0; i < 14; i++) do_move(B_U, "climb");
    for (int i = 0; i < 3; i++) do_move(B_R, "to_coin2");
    chk("coin2/score", 32'(score), 3);
    do_move(B_U, "top_bound");
    chk("top_bound/row", 32'(player_row), 0);

    // Finish while still closed
    for (int i = 0; i < 9; i++) do_move(B_R, "to_finish");
    chk("closed_finish/phase", 32'(phase), 1);
    chk("closed_finish/done", 32'(game_done), 0);

    // Last coin opens the finish
    do_move(B_D, "coin3");
    chk("coin3/score", 32'(score), 4);
    chk("coin3/coin_valid", 32'(coin_valid), 0);
    chk("coin3/finish_open", 32'(finish_open), 1);
    do_move(B_U, "finish");
    chk("finish/done", 32'(game_done), 1);
    chk("finish/phase", 32'(phase), 2);
    do_move(B_D, "done_hold_d");
    do_move(B_L, "done_hold_l");

    // Reset while a move is in CHECK
    do_reset();
    wait_cnt0();
    Right = 1'b1;
    repeat (TD) @(posedge move_clk);
    #1;
    Right = 1'b0;
    @(posedge move_clk); #1;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all("midcheck_rst");
    repeat (2) @(posedge move_clk);
    #1;
    check_all("midcheck_rst_held");
    chk("midcheck_rst/addr", 32'(bus.maze_row_addr), 14);
    @(negedge move_clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge move_clk);
    #1;
    m_phase = 1;

    // Random walls and buttons
    for (int r = 0; r < 15; r++)
      rows[r] = 60'({$urandom(), $urandom()} & {$urandom(), $urandom()});
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [3:0] btn;
      btn = 4'($urandom_range(0, 15));
      do_move(btn, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
